instr_mem_loader: RTL

// - Write-side counterpart of the core's read-only instruction-memory port: streams a program

---
 rtl/nucleo_pkg.sv | 21 ++
 rtl/instr_mem_loader_byte_packer.sv | 40 ++++
 rtl/instr_mem_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/nucleo_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding and the word/byte geometry of the
// big-endian instruction stream (4 bytes per word, byte address = word << 2).
package nucleo_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_ADDR_SHIFT = 2;
    localparam int HDR_WIDTH       = 16;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Assembles host bytes into one instruction word, most significant byte first.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clr         - empty the word and the byte counter
//   shift_en    - shift byte_in into the low end of the word
//   byte_in     - host byte
//   word        - word assembled so far (registered)
//   word_full   - high in the cycle whose shift completes the word
module byte_packer
    import nucleo_pkg::*;
#(
    parameter int SIZE_DATA = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic [7:0]           byte_in,
    output logic [SIZE_DATA-1:0] word,
    output logic                 word_full
);

    logic [1:0] byte_count;

    // Shifting left means the first byte received ends up in the top byte.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            word       <= '0;
            byte_count <= '0;
        end else if (shift_en) begin
            word       <= {word[SIZE_DATA-9:0], byte_in};
            byte_count <= byte_count + 2'd1;
        end
    end

    // Combinational so the FSM can leave DATA on the same edge that takes
    // the final byte, keeping last-byte-to-write latency at one cycle.
    assign word_full = shift_en && (byte_count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program from a host byte link into instruction memory.
// Frame: 16-bit word count N (MSB first), then N big-endian 32-bit words.
// The core is held in reset while loading and released on success.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   load_start            - pulse to begin a load (honoured only when idle)
//   byte_valid/byte_data  - host byte link, transfer when byte_ready is also high
//   byte_ready            - loader can take a byte this cycle
//   mem_we/mem_addr/mem_wdata - one-cycle instruction-memory write
//   core_reset            - holds the core while a load is in progress or failed
//   load_done             - one-cycle pulse on successful completion
//   load_error            - sticky oversize-load flag, cleared by the next load_start
module instr_mem_loader
    import nucleo_pkg::*;
#(
    parameter int ADD_INST_SIZE = 32,
    parameter int SIZE_DATA     = 32,
    parameter int MEM_WORDS     = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     mem_we,
    output logic [ADD_INST_SIZE-1:0] mem_addr,
    output logic [SIZE_DATA-1:0]     mem_wdata,
    output logic                     core_reset,
    output logic                     load_done,
    output logic                     load_error
);

    localparam int                   IDX_W     = $clog2(MEM_WORDS) + 1;
    localparam logic [HDR_WIDTH-1:0] MAX_WORDS = HDR_WIDTH'(MEM_WORDS);

    loader_state_t            state;
    loader_state_t            next_state;
    logic [HDR_WIDTH-1:0]     word_count;
    logic [IDX_W-1:0]         word_index;
    logic [HDR_WIDTH-1:0]     hdr_count;
    logic [HDR_WIDTH-1:0]     index_plus1;
    logic                     xfer;
    logic                     start;
    logic                     pack_clr;
    logic                     pack_shift;
    logic                     word_full;
    logic [SIZE_DATA-1:0]     packed_word;

    logic                     byte_ready_d;
    logic                     mem_we_d;
    logic [ADD_INST_SIZE-1:0] mem_addr_d;
    logic                     core_reset_d;
    logic                     load_done_d;
    logic                     load_error_d;

    assign xfer        = byte_valid && byte_ready;
    assign start       = (state == IDLE) && load_start;
    // Full count as it will be once the low header byte is latched.
    assign hdr_count   = {word_count[HDR_WIDTH-1:8], byte_data};
    assign index_plus1 = HDR_WIDTH'(word_index) + 16'd1;
    assign pack_clr    = start || (state == WRITE);
    assign pack_shift  = (state == DATA) && xfer;

    byte_packer #(
        .SIZE_DATA (SIZE_DATA)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (pack_clr),
        .shift_en  (pack_shift),
        .byte_in   (byte_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    // The packer word is already a register and is stable through WRITE.
    assign mem_wdata = packed_word;

    // State register, header count, word index and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word_count <= '0;
            word_index <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            core_reset <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= next_state;
            byte_ready <= byte_ready_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            core_reset <= core_reset_d;
            load_done  <= load_done_d;
            load_error <= load_error_d;
            if (state == HDR_HI && xfer)
                word_count[HDR_WIDTH-1:8] <= byte_data;
            if (state == HDR_LO && xfer)
                word_count[7:0] <= byte_data;
            if (start)
                word_index <= '0;
            else if (state == WRITE)
                word_index <= word_index + 1'b1;
        end
    end

    // Next-state logic; stalls in place whenever no byte transfers.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (load_start) next_state = HDR_HI;
            HDR_HI: if (xfer) next_state = HDR_LO;
            HDR_LO: begin
                if (xfer) begin
                    if (hdr_count == '0)
                        next_state = DONE;
                    else if (hdr_count > MAX_WORDS)
                        next_state = ERR;
                    else
                        next_state = DATA;
                end
            end
            DATA:   if (word_full) next_state = WRITE;
            WRITE:  next_state = (index_plus1 == word_count) ? DONE : DATA;
            DONE:   next_state = IDLE;
            ERR:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so that, once registered,
    // they line up with the state they belong to.
    always_comb begin
        byte_ready_d = (next_state == HDR_HI) || (next_state == HDR_LO) ||
                       (next_state == DATA);
        mem_we_d     = (next_state == WRITE);
        load_done_d  = (next_state == DONE);
        mem_addr_d   = mem_addr;
        core_reset_d = core_reset;
        load_error_d = load_error;
        if (start) begin
            core_reset_d = 1'b1;
            load_error_d = 1'b0;
        end
        if (next_state == WRITE)
            mem_addr_d = ADD_INST_SIZE'(word_index) << WORD_ADDR_SHIFT;
        if (next_state == DONE)
            core_reset_d = 1'b0;
        // core_reset is left set on error so the core stays held.
        if (next_state == ERR)
            load_error_d = 1'b1;
    end

endmodule
